// File: rtl/pipeline_run_ctrl.sv
// pipeline_run_ctrl: sequences core reset after start, counts cycles/retires, detects halt or timeout
module pipeline_run_ctrl #(
  parameter int PC_W = 32,
  parameter int INSTR_W = 32,
  parameter int CNT_W = 32,
  parameter int RESET_CYCLES = 2,
  parameter logic [INSTR_W-1:0] HALT_INSTR = INSTR_W'(32'h0000006F),
  parameter int HALT_WINDOW = 4,
  parameter int MAX_CYCLES = 5000
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               start,
  input  logic               wb_valid,
  input  logic [PC_W-1:0]    wb_pc,
  input  logic [INSTR_W-1:0] wb_instr,
  output logic               core_reset_n,
  output logic               run,
  output logic               done,
  output logic               timeout,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   retire_cnt,
  output logic [PC_W-1:0]    halt_pc
);
  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam int SW = $clog2(HALT_WINDOW + 1);
  typedef enum logic [2:0] {IDLE, HOLD, RUN, DONE, TIMEOUT} state_t;
  state_t state, state_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [SW-1:0] same_cnt, same_n, same_upd;
  logic [PC_W-1:0] last_pc, last_n, hpc_n;
  logic [CNT_W-1:0] cyc_n, ret_n;
  logic halt;
  // next-state and next-datapath values; a start clears all run status and the same-PC tracker
  always_comb begin
    state_n = state;
    hold_n = hold_cnt;
    cyc_n = cycle_cnt;
    ret_n = retire_cnt;
    hpc_n = halt_pc;
    last_n = last_pc;
    same_n = same_cnt;
    same_upd = (wb_pc == last_pc) ? same_cnt + 1'b1 : SW'(1);
    halt = wb_valid && (wb_instr == HALT_INSTR || same_upd == SW'(HALT_WINDOW));
    case (state)
      HOLD: begin
        hold_n = hold_cnt + 1'b1;
        state_n = (hold_cnt == HW'(RESET_CYCLES - 1)) ? RUN : HOLD;
      end
      RUN: begin
        cyc_n = &cycle_cnt ? cycle_cnt : cycle_cnt + 1'b1;
        if (wb_valid) begin
          ret_n = &retire_cnt ? retire_cnt : retire_cnt + 1'b1;
          last_n = wb_pc;
          same_n = same_upd;
        end
        if (halt) begin
          state_n = DONE;
          hpc_n = wb_pc;
        end else if (cycle_cnt == CNT_W'(MAX_CYCLES - 1)) begin
          state_n = TIMEOUT;
        end
      end
      default: begin
        if (start) begin
          state_n = HOLD;
          hold_n = '0;
          cyc_n = '0;
          ret_n = '0;
          hpc_n = '0;
          last_n = '0;
          same_n = '0;
        end
      end
    endcase
  end
  // state/datapath registers with registered status outputs decoded from the next state
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state <= IDLE;
      hold_cnt <= '0;
      cycle_cnt <= '0;
      retire_cnt <= '0;
      halt_pc <= '0;
      last_pc <= '0;
      same_cnt <= '0;
      core_reset_n <= 1'b0;
      run <= 1'b0;
      done <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      hold_cnt <= hold_n;
      cycle_cnt <= cyc_n;
      retire_cnt <= ret_n;
      halt_pc <= hpc_n;
      last_pc <= last_n;
      same_cnt <= same_n;
      core_reset_n <= (state_n == RUN) || (state_n == DONE) || (state_n == TIMEOUT);
      run <= state_n == RUN;
      done <= state_n == DONE;
      timeout <= state_n == TIMEOUT;
    end
  end
endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// tb_pipeline_run_ctrl: directed scoreboard bench for the run controller
module tb_pipeline_run_ctrl;
  logic clk = 1'b0;
  logic reset, start, wb_valid;
  logic [31:0] wb_pc, wb_instr;
  logic core_reset_n, run, done, timeout;
  logic [31:0] cycle_cnt, retire_cnt, halt_pc;
  int n_cmp = 0;
  int n_err = 0;
  typedef struct {
    string tag;
    logic [3:0] flags;
    logic [31:0] cyc;
    logic [31:0] ret;
    logic [31:0] hpc;
  } exp_t;
  exp_t q[$];

  pipeline_run_ctrl #(.MAX_CYCLES(100)) dut (
    .CLK(clk), .reset(reset), .start(start), .wb_valid(wb_valid),
    .wb_pc(wb_pc), .wb_instr(wb_instr), .core_reset_n(core_reset_n),
    .run(run), .done(done), .timeout(timeout), .cycle_cnt(cycle_cnt),
    .retire_cnt(retire_cnt), .halt_pc(halt_pc)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // flags are {core_reset_n, run, done, timeout}
  task automatic expect_now(input string tag, input logic [3:0] f, input logic [31:0] c, input logic [31:0] r, input logic [31:0] h);
    exp_t e;
    e.tag = tag; e.flags = f; e.cyc = c; e.ret = r; e.hpc = h;
    q.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [3:0] f;
    while (q.size() > 0) begin
      e = q.pop_front();
      f = {core_reset_n, run, done, timeout};
      n_cmp++;
      assert (f === e.flags) else begin
        n_err++;
        $error("FAIL %s flags got %b exp %b", e.tag, f, e.flags);
      end
      n_cmp++;
      assert (cycle_cnt === e.cyc) else begin
        n_err++;
        $error("FAIL %s cycle_cnt got %0d exp %0d", e.tag, cycle_cnt, e.cyc);
      end
      n_cmp++;
      assert (retire_cnt === e.ret) else begin
        n_err++;
        $error("FAIL %s retire_cnt got %0d exp %0d", e.tag, retire_cnt, e.ret);
      end
      n_cmp++;
      assert (halt_pc === e.hpc) else begin
        n_err++;
        $error("FAIL %s halt_pc got %h exp %h", e.tag, halt_pc, e.hpc);
      end
    end
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] ins);
    wb_valid = 1'b1; wb_pc = pc; wb_instr = ins;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic launch();
    start = 1'b1;
    step();
    start = 1'b0;
    step(2);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; wb_valid = 1'b0; wb_pc = '0; wb_instr = '0;
    step(3);
    expect_now("reset", 4'b0000, 0, 0, 0); check();
    reset = 1'b1;
    step(2);
    expect_now("idle", 4'b0000, 0, 0, 0); check();

    start = 1'b1;
    step();
    start = 1'b0;
    expect_now("hold_k", 4'b0000, 0, 0, 0); check();
    step();
    expect_now("hold_k1", 4'b0000, 0, 0, 0); check();
    step();
    expect_now("run_k2", 4'b1100, 0, 0, 0); check();

    retire(32'h0, 32'h13);
    retire(32'h4, 32'h13);
    retire(32'h8, 32'h13);
    expect_now("run3", 4'b1100, 3, 3, 0); check();
    retire(32'hC, 32'h6F);
    expect_now("halt_instr", 4'b1010, 4, 4, 32'hC); check();
    retire(32'h10, 32'h6F);
    step(3);
    expect_now("done_frozen", 4'b1010, 4, 4, 32'hC); check();

    start = 1'b1;
    step();
    start = 1'b0;
    expect_now("rerun_hold", 4'b0000, 0, 0, 0); check();
    step(2);
    expect_now("rerun_run", 4'b1100, 0, 0, 0); check();
    retire(32'h20, 32'h13);
    step();
    retire(32'h20, 32'h13);
    retire(32'h20, 32'h13);
    expect_now("same3", 4'b1100, 4, 3, 0); check();
    step();
    retire(32'h20, 32'h13);
    expect_now("same4_halt", 4'b1010, 6, 4, 32'h20); check();

    launch();
    retire(32'h20, 32'h13);
    retire(32'h20, 32'h13);
    retire(32'h24, 32'h13);
    retire(32'h20, 32'h13);
    expect_now("broken_run", 4'b1100, 4, 4, 0); check();
    step(95);
    expect_now("pre_timeout", 4'b1100, 99, 4, 0); check();
    step();
    expect_now("timeout", 4'b1001, 100, 4, 0); check();
    retire(32'h20, 32'h6F);
    step(2);
    expect_now("timeout_frozen", 4'b1001, 100, 4, 0); check();

    launch();
    step(99);
    expect_now("pre_edge", 4'b1100, 99, 0, 0); check();
    retire(32'h40, 32'h6F);
    expect_now("halt_wins", 4'b1010, 100, 1, 32'h40); check();

    launch();
    step(30);
    start = 1'b1;
    step();
    start = 1'b0;
    expect_now("start_ignored", 4'b1100, 31, 0, 0); check();
    step(6);
    expect_now("cycle37", 4'b1100, 37, 0, 0); check();
    reset = 1'b0;
    step();
    reset = 1'b1;
    expect_now("mid_reset", 4'b0000, 0, 0, 0); check();
    step(2);
    expect_now("after_reset", 4'b0000, 0, 0, 0); check();
    launch();
    step(5);
    expect_now("restart", 4'b1100, 5, 0, 0); check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipeline_run_ctrl.md
Name: pipeline_run_ctrl

Overview:
Synthesizable run controller that wraps a pipelined core under test. It sequences the core's reset after a start request and counts cycles and retired instructions. It detects program end by a halt instruction or a PC self-loop, and flags a timeout. It replaces fixed-delay reset and fixed-time stop in simulation tops, and it is reusable on-board for bring-up. It sits beside the core, driving the core's reset and observing its write-back stage.

Parameters:
PC_W, 32, width of write-back PC.
INSTR_W, 32, width of write-back instruction word.
CNT_W, 32, width of cycle and retire counters.
RESET_CYCLES, 2, cycles core_reset_n is held low after start (>=1).
HALT_INSTR, 32'h0000006F, instruction encoding treated as halt (jal x0,0).
HALT_WINDOW, 4, consecutive retires at the same PC that count as a halt (>=2).
MAX_CYCLES, 5000, RUN cycles allowed before timeout (>=1).

Ports:
CLK  in  1  clock; all logic on rising edge.
reset  in  1  synchronous, active-low; sampled on rising CLK.
start  in  1  start request; level sampled in IDLE/DONE/TIMEOUT only.
wb_valid  in  1  one instruction retires this cycle.
wb_pc  in  PC_W  PC of the retiring instruction.
wb_instr  in  INSTR_W  encoding of the retiring instruction.
core_reset_n  out  1  active-low reset to core (registered).
run  out  1  high while in RUN.
done  out  1  high in DONE (halt detected).
timeout  out  1  high in TIMEOUT.
cycle_cnt  out  CNT_W  cycles spent in RUN.
retire_cnt  out  CNT_W  instructions retired in RUN.
halt_pc  out  PC_W  PC of the instruction that triggered halt.

Behaviour:
- Reset (reset==0 at an edge), from any state: state=IDLE. Outputs go to core_reset_n=0, run=0, done=0, timeout=0, all counters 0, halt_pc=0, same-PC tracker cleared. Reset mid-RUN aborts the run; no partial status is kept.
- States: IDLE, HOLD, RUN, DONE, TIMEOUT. Outputs are registered and decoded from state.
- IDLE: core_reset_n=0. start=1 -> HOLD, hold_cnt=0, cycle_cnt=retire_cnt=0, halt_pc=0.
- HOLD: core_reset_n=0. hold_cnt increments each edge. At the edge where hold_cnt==RESET_CYCLES-1 -> RUN and core_reset_n=1. core_reset_n is therefore low for exactly RESET_CYCLES cycles after the start edge. start is ignored in HOLD and RUN.
- RUN: run=1, core_reset_n=1.
  - cycle_cnt +1 every edge.
  - retire_cnt +1 on each wb_valid.
  - Both counters saturate at all-ones; there is no wrap.
- Same-PC tracker, on each wb_valid:
  - wb_pc equal to last retired PC: same_cnt +1.
  - Otherwise: same_cnt=1 and last PC is updated.
  - wb_valid=0 leaves the tracker unchanged.
- Halt event: wb_valid && (wb_instr==HALT_INSTR || the updated same_cnt==HALT_WINDOW). On a halt event -> DONE, halt_pc=wb_pc. The halting instruction is counted in retire_cnt, and cycle_cnt counts that cycle.
- Timeout: at an edge with cycle_cnt==MAX_CYCLES-1 and no halt event -> TIMEOUT; cycle_cnt becomes MAX_CYCLES. If halt and timeout occur on the same edge, halt wins (DONE).
- DONE/TIMEOUT:
  - Counters and halt_pc are frozen; run=0.
  - core_reset_n stays 1, so core state remains inspectable.
  - wb inputs are ignored.
  - start=1 -> HOLD with counters cleared (re-run).
- done and timeout are mutually exclusive; at most one of run/done/timeout is high.

Test Plan:
1. Reset low 3 cycles, then high, start=0 -> core_reset_n=0, run=0, all counters 0, stays IDLE.
2. Defaults, start pulse at edge k -> core_reset_n low through edge k+1, high after edge k+2. run rises with core_reset_n.
3. RUN, retire PCs 0x0,0x4,0x8, then wb_instr=0x0000006F at pc 0xC -> done=1, halt_pc=0xC, retire_cnt=4, counters frozen afterwards.
4. RUN, retire pc 0x20 four times consecutively (non-halt encoding), with a wb_valid=0 gap in between -> done=1 on the 4th retire, halt_pc=0x20. Variant with 0x20,0x20,0x24,0x20 -> no halt.
5. MAX_CYCLES=100, no halt -> timeout=1 after 100 RUN cycles, cycle_cnt=100, done=0. Variant with a halt retire on cycle 100 -> done=1, timeout=0.
6. Assert reset mid-RUN at cycle 37 -> next edge state IDLE, core_reset_n=0, cycle_cnt=0. Later start from DONE -> re-run with counters restarting at 0.
